// File: rtl/work_dispatcher.sv
// Host-side job dispatcher: parses A5-framed jobs from a byte stream, drives and restarts
// the block solver, and reports its terminal result/nonce (or a NAK) back as bytes.
module work_dispatcher #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int RST_PULSE      = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic [255:0] midstate,
  output logic [95:0]  header_leftovers,
  output logic [255:0] target,
  output logic         solver_rst_n,
  input  logic [2:0]   solver_state,
  input  logic [31:0]  solver_nonce,
  output logic         busy
);
  localparam logic [7:0] SYNC   = 8'hA5;
  localparam logic [7:0] NAK    = 8'hEE;
  localparam logic [7:0] HDR_OK = 8'h5A;
  localparam logic [7:0] HDR_NS = 8'h5F;
  localparam int         PAY_BYTES = 76;

  typedef enum logic [1:0] {P_HUNT, P_PAYLOAD, P_CHECK} pstate_t;
  typedef enum logic [1:0] {J_IDLE, J_PULSE, J_ARMING, J_RUN} jstate_t;

  pstate_t        r_pst, w_pst_nxt;
  jstate_t        r_jst, w_jst_nxt;
  logic [607:0]   r_stage;
  logic [6:0]     r_cnt;
  logic [7:0]     r_csum;
  logic [31:0]    r_tmo;
  logic [31:0]    r_pcnt;
  logic           r_rx_en;
  logic [7:0]     r_tx_data;
  logic           r_tx_valid;
  logic [31:0]    r_tx_rest;
  logic [2:0]     r_tx_left;
  logic           r_srst_n;
  logic           r_busy;
  logic [255:0]   r_midstate;
  logic [95:0]    r_hl;
  logic [255:0]   r_target;

  logic w_rx_fire, w_tx_fire, w_good, w_bad, w_timeout, w_term;

  // The single tx slot gates reception so a NAK can never land on a pending report.
  assign rx_ready  = r_rx_en & ~r_tx_valid;
  assign w_rx_fire = rx_valid & rx_ready;
  assign w_tx_fire = r_tx_valid & tx_ready;
  assign w_timeout = (r_pst != P_HUNT) && !w_rx_fire && (r_tmo == 32'(TIMEOUT_CYCLES - 1));
  assign w_good    = (r_pst == P_CHECK) && w_rx_fire && (rx_data == r_csum);
  assign w_bad     = (r_pst == P_CHECK) && w_rx_fire && (rx_data != r_csum);
  // A new job beats a same-cycle result; a result beats a same-cycle NAK.
  assign w_term    = (r_jst == J_RUN) && !r_tx_valid && !w_good &&
                     ((solver_state == 3'd4) || (solver_state == 3'd5));

  assign tx_data          = r_tx_data;
  assign tx_valid         = r_tx_valid;
  assign solver_rst_n     = r_srst_n;
  assign busy             = r_busy;
  assign midstate         = r_midstate;
  assign header_leftovers = r_hl;
  assign target           = r_target;

  always_comb begin
    w_pst_nxt = r_pst;
    unique case (r_pst)
      P_HUNT:    if (w_rx_fire && rx_data == SYNC) w_pst_nxt = P_PAYLOAD;
      P_PAYLOAD: if (w_timeout) w_pst_nxt = P_HUNT;
                 else if (w_rx_fire && r_cnt == 7'(PAY_BYTES - 1)) w_pst_nxt = P_CHECK;
      P_CHECK:   if (w_timeout || w_rx_fire) w_pst_nxt = P_HUNT;
      default:   w_pst_nxt = P_HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pst   <= P_HUNT;
      r_stage <= '0;
      r_cnt   <= '0;
      r_csum  <= '0;
      r_tmo   <= '0;
    end else begin
      r_pst <= w_pst_nxt;
      if (w_rx_fire || r_pst == P_HUNT) r_tmo <= '0;
      else                              r_tmo <= r_tmo + 32'd1;
      if (r_pst == P_HUNT) begin
        r_cnt  <= '0;
        r_csum <= '0;
      end else if (r_pst == P_PAYLOAD && w_rx_fire) begin
        r_stage <= {r_stage[599:0], rx_data};
        r_csum  <= r_csum ^ rx_data;
        r_cnt   <= r_cnt + 7'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_midstate <= '0;
      r_hl       <= '0;
      r_target   <= '0;
    end else if (w_good) begin
      r_midstate <= r_stage[607:352];
      r_hl       <= r_stage[351:256];
      r_target   <= r_stage[255:0];
    end
  end

  // ARMING waits for a non-terminal state so a stale result from before the restart is ignored.
  always_comb begin
    w_jst_nxt = r_jst;
    unique case (r_jst)
      J_IDLE:   w_jst_nxt = J_IDLE;
      J_PULSE:  if (r_pcnt == 32'(RST_PULSE - 1)) w_jst_nxt = J_ARMING;
      J_ARMING: if (solver_state <= 3'd3) w_jst_nxt = J_RUN;
      J_RUN:    if (w_term) w_jst_nxt = J_IDLE;
      default:  w_jst_nxt = J_IDLE;
    endcase
    if (w_good) w_jst_nxt = J_PULSE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_jst    <= J_IDLE;
      r_pcnt   <= '0;
      r_srst_n <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_jst <= w_jst_nxt;
      if (w_good || r_jst != J_PULSE) r_pcnt <= '0;
      else                            r_pcnt <= r_pcnt + 32'd1;
      r_srst_n <= (w_jst_nxt == J_ARMING) || (w_jst_nxt == J_RUN);
      r_busy   <= (w_jst_nxt != J_IDLE);
    end
  end

  // r_tx_left counts bytes still queued behind the one on tx_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_en    <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
      r_tx_rest  <= '0;
      r_tx_left  <= '0;
    end else begin
      r_rx_en <= 1'b1;
      if (w_term) begin
        r_tx_valid <= 1'b1;
        r_tx_data  <= (solver_state == 3'd4) ? HDR_OK : HDR_NS;
        r_tx_rest  <= solver_nonce;
        r_tx_left  <= 3'd4;
      end else if (w_bad) begin
        r_tx_valid <= 1'b1;
        r_tx_data  <= NAK;
        r_tx_left  <= 3'd0;
      end else if (w_tx_fire) begin
        if (r_tx_left == 3'd0) begin
          r_tx_valid <= 1'b0;
        end else begin
          r_tx_data <= r_tx_rest[31:24];
          r_tx_rest <= {r_tx_rest[23:0], 8'h00};
          r_tx_left <= r_tx_left - 3'd1;
        end
      end
    end
  end
endmodule
